id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pkg.sv | 39 +++
 rtl/id_ex_stage_if.sv | 27 ++
 rtl/mips_decoder.sv | 61 ++++++
 rtl/id_ex_stage.sv | 116 +++++++++++
 tb/tb_id_ex_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU operation encodings and the decoded-instruction record.
package mips_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluSlt = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic [4:0]  dst;
        alu_op_e     alu_op;
        logic        alu_src;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
        logic        uses_rt;   // rt is a source operand (R-type, sw)
        logic [31:0] imm;
    } dec_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register payload as seen by the execute stage.
interface id_ex_stage_if #(
    parameter int unsigned DW = 32
);
    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [DW-1:0] ex_imm;
    logic [4:0]    ex_dst;
    logic [2:0]    ex_alu_op;
    logic          ex_alu_src;
    logic          ex_reg_wr;
    logic          ex_mem_rd;
    logic          ex_mem_wr;
    logic          ex_illegal;

    modport master (
        output ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_dst, ex_alu_op,
        output ex_alu_src, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_illegal
    );

    modport slave (
        input ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_dst, ex_alu_op,
        input ex_alu_src, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_illegal
    );
endinterface

// File: rtl/mips_decoder.sv
// Combinational MIPS subset decoder: add/sub/and/or/slt, addi, lw, sw.
module mips_decoder
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_bits = ^{instr[25:21], instr[10:6]};

    always_comb begin
        dec        = '0;
        dec.alu_op = AluAdd;
        dec.imm    = sext16(instr[15:0]);
        case (op)
            OpRtype: begin
                dec.imm     = '0;
                dec.dst     = instr[15:11];
                dec.reg_wr  = 1'b1;
                dec.uses_rt = 1'b1;
                case (funct)
                    FnAdd:   dec.alu_op = AluAdd;
                    FnSub:   dec.alu_op = AluSub;
                    FnAnd:   dec.alu_op = AluAnd;
                    FnOr:    dec.alu_op = AluOr;
                    FnSlt:   dec.alu_op = AluSlt;
                    default: begin
                        dec.illegal = 1'b1;
                        dec.reg_wr  = 1'b0;
                    end
                endcase
            end
            OpAddi: begin
                dec.dst     = instr[20:16];
                dec.alu_src = 1'b1;
                dec.reg_wr  = 1'b1;
            end
            OpLw: begin
                dec.dst     = instr[20:16];
                dec.alu_src = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.reg_wr  = 1'b1;
            end
            OpSw: begin
                dec.alu_src = 1'b1;
                dec.mem_wr  = 1'b1;
                dec.uses_rt = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // $0 is hardwired: never a real write target
        if (dec.dst == 5'd0) begin
            dec.reg_wr = 1'b0;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with writeback bypass, load-use stall detection and the ID/EX register.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [DW-1:0]   if_pc,
    output logic [4:0]      radr1,
    output logic [4:0]      radr2,
    input  logic [DW-1:0]   dout1,
    input  logic [DW-1:0]   dout2,
    input  logic            wb_wr_en,
    input  logic [4:0]      wb_adr,
    input  logic [DW-1:0]   wb_data,
    input  logic            flush,
    output logic            id_stall,
    output logic [CNTW-1:0] stall_cnt,
    id_ex_stage_if.master   ex
);
    dec_t          dec;
    logic [DW-1:0] opnd_a;
    logic [DW-1:0] opnd_b;
    logic          hazard;

    logic          ex_valid_q;
    logic [DW-1:0] ex_pc_q;
    logic [DW-1:0] ex_a_q;
    logic [DW-1:0] ex_b_q;
    logic [DW-1:0] ex_imm_q;
    logic [4:0]    ex_dst_q;
    alu_op_e       ex_alu_op_q;
    logic          ex_alu_src_q;
    logic          ex_reg_wr_q;
    logic          ex_mem_rd_q;
    logic          ex_mem_wr_q;
    logic          ex_illegal_q;
    logic [CNTW-1:0] stall_cnt_q;

    mips_decoder u_decoder (
        .instr (if_instr),
        .dec   (dec)
    );

    assign radr1 = if_instr[25:21];
    assign radr2 = if_instr[20:16];

    assign opnd_a = (wb_wr_en && wb_adr != 5'd0 && wb_adr == radr1) ? wb_data : dout1;
    assign opnd_b = (wb_wr_en && wb_adr != 5'd0 && wb_adr == radr2) ? wb_data : dout2;

    // Load in EX whose result a source operand of the decode instruction needs
    assign hazard = if_valid & ex_valid_q & ex_mem_rd_q & (ex_dst_q != 5'd0) &
                    ((ex_dst_q == radr1) | ((ex_dst_q == radr2) & dec.uses_rt));

    assign id_stall = hazard & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_imm_q     <= '0;
            ex_dst_q     <= '0;
            ex_alu_op_q  <= AluAdd;
            ex_alu_src_q <= 1'b0;
            ex_reg_wr_q  <= 1'b0;
            ex_mem_rd_q  <= 1'b0;
            ex_mem_wr_q  <= 1'b0;
            ex_illegal_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            if (flush || hazard) begin
                ex_valid_q   <= 1'b0;
                ex_reg_wr_q  <= 1'b0;
                ex_mem_rd_q  <= 1'b0;
                ex_mem_wr_q  <= 1'b0;
                ex_illegal_q <= 1'b0;
            end else begin
                ex_valid_q   <= if_valid;
                ex_pc_q      <= if_pc;
                ex_a_q       <= opnd_a;
                ex_b_q       <= opnd_b;
                ex_imm_q     <= dec.imm;
                ex_dst_q     <= dec.dst;
                ex_alu_op_q  <= dec.alu_op;
                ex_alu_src_q <= dec.alu_src;
                ex_reg_wr_q  <= dec.reg_wr;
                ex_mem_rd_q  <= dec.mem_rd;
                ex_mem_wr_q  <= dec.mem_wr;
                ex_illegal_q <= dec.illegal;
            end
            if (id_stall && stall_cnt_q != {CNTW{1'b1}}) begin
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
            end
        end
    end

    assign stall_cnt     = stall_cnt_q;
    assign ex.ex_valid   = ex_valid_q;
    assign ex.ex_pc      = ex_pc_q;
    assign ex.ex_a       = ex_a_q;
    assign ex.ex_b       = ex_b_q;
    assign ex.ex_imm     = ex_imm_q;
    assign ex.ex_dst     = ex_dst_q;
    assign ex.ex_alu_op  = ex_alu_op_q;
    assign ex.ex_alu_src = ex_alu_src_q;
    assign ex.ex_reg_wr  = ex_reg_wr_q;
    assign ex.ex_mem_rd  = ex_mem_rd_q;
    assign ex.ex_mem_wr  = ex_mem_wr_q;
    assign ex.ex_illegal = ex_illegal_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: decode table, hazard/flush/reset sequences, random vs model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] dout1;
    logic [31:0] dout2;
    logic        wb_wr_en;
    logic [4:0]  wb_adr;
    logic [31:0] wb_data;
    logic        flush;

    logic [4:0]  radr1, radr2, radr1_s, radr2_s;
    logic        id_stall, id_stall_s;
    logic [15:0] stall_cnt;
    logic [2:0]  stall_cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(32)) exi ();
    id_ex_stage_if #(.DW(32)) exs ();

    id_ex_stage #(.DW(32), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .radr1(radr1), .radr2(radr2), .dout1(dout1), .dout2(dout2), .wb_wr_en(wb_wr_en),
        .wb_adr(wb_adr), .wb_data(wb_data), .flush(flush), .id_stall(id_stall),
        .stall_cnt(stall_cnt), .ex(exi)
    );

    // Narrow counter instance so saturation is reached within a short run
    id_ex_stage #(.DW(32), .CNTW(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .radr1(radr1_s), .radr2(radr2_s), .dout1(dout1), .dout2(dout2), .wb_wr_en(wb_wr_en),
        .wb_adr(wb_adr), .wb_data(wb_data), .flush(flush), .id_stall(id_stall_s),
        .stall_cnt(stall_cnt_s), .ex(exs)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2);
        if_valid = 1'b1; if_instr = ins; if_pc = pc; dout1 = d1; dout2 = d2;
        wb_wr_en = 1'b0; wb_adr = 5'd0; wb_data = 32'h0; flush = 1'b0;
    endtask

    task automatic do_reset();
        if_valid = 1'b0; flush = 1'b0; wb_wr_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Reference decode, from the instruction-set rules
    localparam logic [5:0] RFUNCT [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    typedef struct packed {
        logic        ill;
        logic        uses_rt;
        logic        is_sw;
        logic [4:0]  dst;
        logic [2:0]  aop;
        logic        src;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] imm;
    } mdec_t;

    function automatic mdec_t mdec(input logic [31:0] ins);
        mdec_t d;
        logic [5:0] op;
        op = ins[31:26];
        d = '0;
        d.ill = 1'b1;
        d.imm = {{16{ins[15]}}, ins[15:0]};
        if (op == 6'h00) begin
            d.uses_rt = 1'b1; d.imm = 32'h0; d.dst = ins[15:11];
            for (int k = 0; k < 5; k++) begin
                if (ins[5:0] == RFUNCT[k]) begin
                    d.ill = 1'b0; d.aop = 3'(k);
                end
            end
            d.rw = ~d.ill;
        end else if (op == 6'h08) begin
            d.ill = 1'b0; d.dst = ins[20:16]; d.src = 1'b1; d.rw = 1'b1;
        end else if (op == 6'h23) begin
            d.ill = 1'b0; d.dst = ins[20:16]; d.src = 1'b1; d.rw = 1'b1; d.mr = 1'b1;
        end else if (op == 6'h2B) begin
            d.ill = 1'b0; d.src = 1'b1; d.mw = 1'b1; d.uses_rt = 1'b1; d.is_sw = 1'b1;
        end
        if (d.dst == 5'd0) d.rw = 1'b0;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int sel;
        ins = $urandom();
        sel = $urandom_range(0, 9);
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        ins[15:11] = 5'($urandom_range(0, 3));
        case (sel)
            0, 1, 2: begin ins[31:26] = 6'h00; ins[5:0] = RFUNCT[$urandom_range(0, 4)]; end
            3:       ins[31:26] = 6'h08;
            4, 5, 6: ins[31:26] = 6'h23;
            7:       ins[31:26] = 6'h2B;
            8:       ins[31:26] = 6'h00;
            default: ins[31:26] = 6'($urandom_range(0, 63));
        endcase
        return ins;
    endfunction

    typedef struct {
        logic [31:0] instr, d1, d2, wen, wadr, wdata, r1, r2, a, b, imm;
        logic [31:0] dst, aop, src, rw, mr, mw, ill, mode;  // mode: 0 all, 1 no dst, 2 control only
    } vec_t;

    vec_t vq[$];

    // Model state for the random phase
    logic        m_valid, m_rw, m_mr, m_mw, m_ill, m_sw, m_src;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_dst;
    logic [2:0]  m_aop;
    int          m_cnt;

    initial begin
        mdec_t d;
        logic  h, stall, hold;
        logic [4:0] rs, rt;

        if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; dout1 = 32'h0; dout2 = 32'h0;
        wb_wr_en = 1'b0; wb_adr = 5'd0; wb_data = 32'h0; flush = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(exi.ex_valid), 0);
        chk("rst_reg_wr", 32'(exi.ex_reg_wr), 0);
        chk("rst_mem_rd", 32'(exi.ex_mem_rd), 0);
        chk("rst_illegal", 32'(exi.ex_illegal), 0);
        chk("rst_pc", exi.ex_pc, 0);
        chk("rst_a", exi.ex_a, 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        tick();
        rst_n = 1'b1;

        // ---------------- decode table ----------------
        vq.push_back('{32'h00221820, 5, 7, 0, 0, 0, 1, 2, 5, 7, 0, 3, 0, 0, 1, 0, 0, 0, 0});
        vq.push_back('{32'h01093822, 32'h10, 3, 0, 0, 0, 8, 9, 32'h10, 3, 0, 7, 1, 0, 1, 0, 0, 0, 0});
        vq.push_back('{32'h016C5024, 32'hF0F0, 32'h0FF0, 0, 0, 0, 11, 12, 32'hF0F0, 32'h0FF0, 0,
                       10, 2, 0, 1, 0, 0, 0, 0});
        vq.push_back('{32'h01CF6825, 1, 2, 0, 0, 0, 14, 15, 1, 2, 0, 13, 3, 0, 1, 0, 0, 0, 0});
        vq.push_back('{32'h0232802A, 9, 8, 0, 0, 0, 17, 18, 9, 8, 0, 16, 4, 0, 1, 0, 0, 0, 0});
        vq.push_back('{32'h2026FFFC, 0, 32'h55, 1, 1, 32'h100, 1, 6, 32'h100, 32'h55, 32'hFFFFFFFC,
                       6, 0, 1, 1, 0, 0, 0, 0});
        vq.push_back('{32'h8C240008, 3, 4, 0, 0, 0, 1, 4, 3, 4, 8, 4, 0, 1, 1, 1, 0, 0, 0});
        vq.push_back('{32'hAC45FFF0, 6, 7, 0, 0, 0, 2, 5, 6, 7, 32'hFFFFFFF0, 0, 0, 1, 0, 0, 1, 0, 1});
        vq.push_back('{32'hFC221820, 1, 2, 0, 0, 0, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2});
        vq.push_back('{32'h00221821, 1, 2, 0, 0, 0, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2});
        vq.push_back('{32'h00220020, 5, 6, 0, 0, 0, 1, 2, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vq.push_back('{32'h00021820, 32'h11, 32'h22, 1, 0, 32'hDEAD, 0, 2, 32'h11, 32'h22, 0,
                       3, 0, 0, 1, 0, 0, 0, 0});
        vq.push_back('{32'h00221820, 1, 2, 1, 2, 32'h77, 1, 2, 1, 32'h77, 0, 3, 0, 0, 1, 0, 0, 0, 0});
        vq.push_back('{32'h00221820, 32'hAA, 32'hBB, 0, 1, 32'h99, 1, 2, 32'hAA, 32'hBB, 0,
                       3, 0, 0, 1, 0, 0, 0, 0});

        foreach (vq[i]) begin
            if_valid = 1'b0;
            tick();
            drive(vq[i].instr, 32'h1000 + 32'(i) * 4, vq[i].d1, vq[i].d2);
            wb_wr_en = vq[i].wen[0]; wb_adr = vq[i].wadr[4:0]; wb_data = vq[i].wdata;
            #2;
            chk($sformatf("tbl%0d_radr1", i), 32'(radr1), vq[i].r1);
            chk($sformatf("tbl%0d_radr2", i), 32'(radr2), vq[i].r2);
            chk($sformatf("tbl%0d_stall", i), 32'(id_stall), 0);
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(exi.ex_valid), 1);
            chk($sformatf("tbl%0d_pc", i), exi.ex_pc, 32'h1000 + 32'(i) * 4);
            chk($sformatf("tbl%0d_a", i), exi.ex_a, vq[i].a);
            chk($sformatf("tbl%0d_b", i), exi.ex_b, vq[i].b);
            chk($sformatf("tbl%0d_reg_wr", i), 32'(exi.ex_reg_wr), vq[i].rw);
            chk($sformatf("tbl%0d_mem_rd", i), 32'(exi.ex_mem_rd), vq[i].mr);
            chk($sformatf("tbl%0d_mem_wr", i), 32'(exi.ex_mem_wr), vq[i].mw);
            chk($sformatf("tbl%0d_illegal", i), 32'(exi.ex_illegal), vq[i].ill);
            if (vq[i].mode != 2) begin
                chk($sformatf("tbl%0d_imm", i), exi.ex_imm, vq[i].imm);
                chk($sformatf("tbl%0d_alu_op", i), 32'(exi.ex_alu_op), vq[i].aop);
                chk($sformatf("tbl%0d_alu_src", i), 32'(exi.ex_alu_src), vq[i].src);
            end
            if (vq[i].mode == 0) chk($sformatf("tbl%0d_dst", i), 32'(exi.ex_dst), vq[i].dst);
        end

        // ---------------- load-use sequences ----------------
        do_reset();
        drive(32'h8C240008, 32'h200, 0, 0);             // lw $4,8($1)
        tick();
        drive(32'h00822820, 32'h204, 1, 2);             // add $5,$4,$2
        #2 chk("lu_stall", 32'(id_stall), 1);
        tick();
        chk("lu_bubble_valid", 32'(exi.ex_valid), 0);
        chk("lu_bubble_reg_wr", 32'(exi.ex_reg_wr), 0);
        chk("lu_bubble_mem_rd", 32'(exi.ex_mem_rd), 0);
        chk("lu_cnt1", 32'(stall_cnt), 1);
        #2 chk("lu_stall_released", 32'(id_stall), 0);
        tick();
        chk("lu_issue_valid", 32'(exi.ex_valid), 1);
        chk("lu_issue_dst", 32'(exi.ex_dst), 5);
        chk("lu_issue_pc", exi.ex_pc, 32'h204);
        chk("lu_cnt_hold", 32'(stall_cnt), 1);

        drive(32'h8C240008, 32'h210, 0, 0);
        tick();
        drive(32'hAC440000, 32'h214, 0, 0);             // sw $4,0($2): rt dependency
        #2 chk("sw_rt_stall", 32'(id_stall), 1);
        tick();
        chk("sw_rt_cnt", 32'(stall_cnt), 2);
        drive(32'h8C240008, 32'h220, 0, 0);
        tick();
        drive(32'h20440001, 32'h224, 0, 0);             // addi $4,$2,1: rt is a destination
        #2 chk("addi_rt_nostall", 32'(id_stall), 0);
        tick();
        chk("addi_rt_valid", 32'(exi.ex_valid), 1);
        drive(32'h8C200008, 32'h230, 0, 0);             // lw $0,8($1)
        tick();
        drive(32'h00002820, 32'h234, 0, 0);
        #2 chk("lw_r0_nostall", 32'(id_stall), 0);
        drive(32'h8C240008, 32'h240, 0, 0);
        tick();
        drive(32'h00822820, 32'h244, 0, 0);
        if_valid = 1'b0;
        #2 chk("invalid_nostall", 32'(id_stall), 0);
        tick();
        chk("cnt_after_nostall", 32'(stall_cnt), 2);

        // ---------------- flush ----------------
        drive(32'h8C240008, 32'h250, 0, 0);
        tick();
        drive(32'h00822820, 32'h254, 0, 0);
        flush = 1'b1;
        #2 chk("flush_hz_stall", 32'(id_stall), 0);
        tick();
        chk("flush_hz_valid", 32'(exi.ex_valid), 0);
        chk("flush_hz_reg_wr", 32'(exi.ex_reg_wr), 0);
        chk("flush_hz_cnt", 32'(stall_cnt), 2);
        drive(32'hFC000000, 32'h260, 0, 0);
        tick();
        chk("ill_valid", 32'(exi.ex_valid), 1);
        chk("ill_flag", 32'(exi.ex_illegal), 1);
        chk("ill_reg_wr", 32'(exi.ex_reg_wr), 0);
        flush = 1'b1;
        tick();
        chk("flush_valid", 32'(exi.ex_valid), 0);
        chk("flush_illegal", 32'(exi.ex_illegal), 0);

        // ---------------- asynchronous reset mid-stall ----------------
        drive(32'h8C240008, 32'h270, 32'h33, 32'h44);
        tick();
        drive(32'h00822820, 32'h274, 0, 0);
        #2 chk("rstm_stall_before", 32'(id_stall), 1);
        rst_n = 1'b0;
        #1;
        chk("rstm_stall", 32'(id_stall), 0);
        chk("rstm_valid", 32'(exi.ex_valid), 0);
        chk("rstm_mem_rd", 32'(exi.ex_mem_rd), 0);
        chk("rstm_reg_wr", 32'(exi.ex_reg_wr), 0);
        chk("rstm_a", exi.ex_a, 0);
        chk("rstm_pc", exi.ex_pc, 0);
        chk("rstm_imm", exi.ex_imm, 0);
        chk("rstm_cnt", 32'(stall_cnt), 0);
        tick();
        rst_n = 1'b1;
        #2 chk("rstm_release_stall", 32'(id_stall), 0);
        tick();
        chk("rstm_issue_valid", 32'(exi.ex_valid), 1);
        chk("rstm_issue_dst", 32'(exi.ex_dst), 5);

        // ---------------- random vs model ----------------
        do_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ill = 0; m_sw = 0; m_src = 0;
        m_pc = 0; m_a = 0; m_b = 0; m_imm = 0; m_dst = 0; m_aop = 0; m_cnt = 0;
        hold = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!hold) begin
                if_valid = ($urandom_range(0, 7) != 0);
                if_instr = rand_instr();
                if_pc = $urandom() & 32'hFFFF_FFFC;
            end
            dout1 = $urandom(); dout2 = $urandom();
            wb_wr_en = 1'($urandom_range(0, 1));
            wb_adr = 5'($urandom_range(0, 3));
            wb_data = $urandom();
            flush = ($urandom_range(0, 11) == 0);
            d = mdec(if_instr);
            rs = if_instr[25:21];
            rt = if_instr[20:16];
            h = if_valid && m_valid && m_mr && m_dst != 0 &&
                (m_dst == rs || (m_dst == rt && d.uses_rt));
            stall = h && !flush;
            #2;
            chk("rnd_radr1", 32'(radr1), 32'(rs));
            chk("rnd_radr2", 32'(radr2), 32'(rt));
            chk("rnd_stall", 32'(id_stall), 32'(stall));
            chk("rnd_stall_sat", 32'(id_stall_s), 32'(stall));
            @(posedge clk);
            if (flush || h) begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ill = 0;
            end else begin
                m_valid = if_valid; m_pc = if_pc;
                m_a = (wb_wr_en && wb_adr != 0 && wb_adr == rs) ? wb_data : dout1;
                m_b = (wb_wr_en && wb_adr != 0 && wb_adr == rt) ? wb_data : dout2;
                m_imm = d.imm; m_dst = d.dst; m_aop = d.aop; m_src = d.src;
                m_rw = d.rw; m_mr = d.mr; m_mw = d.mw; m_ill = d.ill; m_sw = d.is_sw;
            end
            if (stall) m_cnt++;
            #1;
            chk("rnd_valid", 32'(exi.ex_valid), 32'(m_valid));
            chk("rnd_reg_wr", 32'(exi.ex_reg_wr), 32'(m_rw));
            chk("rnd_mem_rd", 32'(exi.ex_mem_rd), 32'(m_mr));
            chk("rnd_mem_wr", 32'(exi.ex_mem_wr), 32'(m_mw));
            chk("rnd_illegal", 32'(exi.ex_illegal), 32'(m_ill));
            chk("rnd_cnt", 32'(stall_cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
            chk("rnd_cnt_sat", 32'(stall_cnt_s), (m_cnt > 7) ? 32'd7 : 32'(m_cnt));
            if (m_valid) begin
                chk("rnd_pc", exi.ex_pc, m_pc);
                chk("rnd_a", exi.ex_a, m_a);
                chk("rnd_b", exi.ex_b, m_b);
                if (!m_ill) begin
                    chk("rnd_imm", exi.ex_imm, m_imm);
                    chk("rnd_alu_op", 32'(exi.ex_alu_op), 32'(m_aop));
                    chk("rnd_alu_src", 32'(exi.ex_alu_src), 32'(m_src));
                    if (!m_sw) chk("rnd_dst", 32'(exi.ex_dst), 32'(m_dst));
                end
            end
            hold = stall;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
